// File: rtl/adc_drp_poller.sv
// adc_drp_poller: autonomous master for the ADC hard-macro register port.
// Periodically sweeps NUM_CH result registers, box-car averages each channel
// over 2^AVG_LOG2 sweeps, publishes averages with per-channel range alarms,
// and interleaves single host configuration reads/writes between sweeps.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   en                       enables the sweep tick counter
//   PADDR..PREADY            register-port master (setup/access handshake)
//   cfg_req..cfg_err         host single-transfer request/ack interface
//   thr_hi, thr_lo           per-channel inclusive limits, 16 bits per channel
//   result, result_valid     averaged values and their one-cycle update pulse
//   alarm                    per-channel out-of-range flags
//   timeout_err, overrun_err sticky error flags, cleared by err_clr
module adc_drp_poller #(
  parameter int unsigned NUM_CH       = 4,
  parameter logic [7:0]  CH_ADDR_BASE = 8'h00,
  parameter int unsigned POLL_DIV     = 1000,
  parameter int unsigned AVG_LOG2     = 2,
  parameter int unsigned TIMEOUT_CYC  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic [7:0]           PADDR,
  output logic                 PSEL,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [15:0]          PWDATA,
  input  logic [15:0]          PRDATA,
  input  logic                 PREADY,
  input  logic                 cfg_req,
  input  logic                 cfg_we,
  input  logic [7:0]           cfg_addr,
  input  logic [15:0]          cfg_wdata,
  output logic [15:0]          cfg_rdata,
  output logic                 cfg_ack,
  output logic                 cfg_err,
  input  logic [NUM_CH*16-1:0] thr_hi,
  input  logic [NUM_CH*16-1:0] thr_lo,
  output logic [NUM_CH*16-1:0] result,
  output logic                 result_valid,
  output logic [NUM_CH-1:0]    alarm,
  output logic                 timeout_err,
  output logic                 overrun_err,
  input  logic                 err_clr
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned DIV_W = $clog2(POLL_DIV);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned ACC_W = 16 + AVG_LOG2;
  localparam int unsigned SW_W  = AVG_LOG2 + 1;
  localparam int unsigned AVG_N = 1 << AVG_LOG2;

  typedef enum logic [2:0] {
    IDLE, SETUP, ACCESS, NEXT, PUBLISH, CFG_SETUP, CFG_ACCESS, CFG_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [DIV_W-1:0]  div_q;
  logic [TO_W-1:0]   wait_q;
  logic [SW_W-1:0]   sweep_q;
  logic [ACC_W-1:0]  acc_q [NUM_CH];
  logic [15:0]       avg_c [NUM_CH];
  logic              pending_q;
  logic              tick_c, consume_c, timeout_c, sweep_to_c, last_ch_c;
  logic [7:0]        paddr_d;
  logic              psel_d, penable_d, pwrite_d;
  logic [15:0]       pwdata_d;

  // Sweep tick generator and the single-entry pending flag
  assign tick_c     = en && (div_q == DIV_W'(POLL_DIV - 1));
  assign consume_c  = (state_q == IDLE) && !cfg_req && pending_q;
  assign last_ch_c  = (ch_q == CH_W'(NUM_CH - 1));
  assign timeout_c  = ((state_q == ACCESS) || (state_q == CFG_ACCESS)) && !PREADY &&
                      (wait_q == TO_W'(TIMEOUT_CYC - 1));
  assign sweep_to_c = (state_q == ACCESS) && timeout_c;

  // Truncating average per channel
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      avg_c[i] = 16'(acc_q[i] >> AVG_LOG2);
    end
  end

  // Next state plus next bus values; the bus is registered from the next state
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    paddr_d   = 8'h00;
    psel_d    = 1'b0;
    penable_d = 1'b0;
    pwrite_d  = 1'b0;
    pwdata_d  = 16'h0000;
    case (state_q)
      IDLE: begin
        if (cfg_req) begin
          state_d = CFG_SETUP;
        end else if (pending_q) begin
          state_d = SETUP;
          ch_d    = '0;
        end
      end
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (PREADY)         state_d = NEXT;
        else if (timeout_c) state_d = IDLE;
      end
      NEXT: begin
        if (!last_ch_c) begin
          ch_d    = ch_q + 1'b1;
          state_d = SETUP;
        end else if (sweep_q == SW_W'(AVG_N - 1)) begin
          state_d = PUBLISH;
        end else begin
          state_d = IDLE;
        end
      end
      PUBLISH:    state_d = IDLE;
      CFG_SETUP:  state_d = CFG_ACCESS;
      CFG_ACCESS: if (PREADY || timeout_c) state_d = CFG_DONE;
      CFG_DONE:   state_d = IDLE;
      default:    state_d = IDLE;
    endcase

    case (state_d)
      SETUP, ACCESS: begin
        psel_d    = 1'b1;
        penable_d = (state_d == ACCESS);
        paddr_d   = CH_ADDR_BASE + 8'(ch_d);
      end
      CFG_SETUP: begin
        psel_d   = 1'b1;
        paddr_d  = cfg_addr;
        pwrite_d = cfg_we;
        pwdata_d = cfg_we ? cfg_wdata : 16'h0000;
      end
      CFG_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        paddr_d   = PADDR;
        pwrite_d  = PWRITE;
        pwdata_d  = PWDATA;
      end
      default: ;
    endcase
  end

  // State, bus and control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ch_q         <= '0;
      div_q        <= '0;
      wait_q       <= '0;
      pending_q    <= 1'b0;
      PADDR        <= 8'h00;
      PSEL         <= 1'b0;
      PENABLE      <= 1'b0;
      PWRITE       <= 1'b0;
      PWDATA       <= 16'h0000;
      cfg_rdata    <= 16'h0000;
      cfg_ack      <= 1'b0;
      cfg_err      <= 1'b0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      PADDR     <= paddr_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      PWRITE    <= pwrite_d;
      PWDATA    <= pwdata_d;
      if (en) div_q <= tick_c ? '0 : div_q + 1'b1;
      // A tick arriving in the same cycle as consumption becomes the new pending
      pending_q <= tick_c | (pending_q & ~consume_c);
      wait_q    <= (((state_q == ACCESS) || (state_q == CFG_ACCESS)) && !PREADY) ?
                   wait_q + 1'b1 : '0;
      cfg_ack      <= (state_d == CFG_DONE);
      cfg_err      <= (state_q == CFG_ACCESS) && timeout_c;
      result_valid <= (state_d == PUBLISH);
      if ((state_q == CFG_ACCESS) && (state_d == CFG_DONE)) begin
        cfg_rdata <= (PREADY && !PWRITE) ? PRDATA : 16'h0000;
      end
      // New error wins over a simultaneous clear
      if (sweep_to_c)   timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
      if (tick_c && pending_q && !consume_c) overrun_err <= 1'b1;
      else if (err_clr)                      overrun_err <= 1'b0;
    end
  end

  // Accumulators and sweep count; a sweep timeout discards the whole window
  always_ff @(posedge clk) begin
    if (rst || (state_q == PUBLISH) || sweep_to_c) begin
      sweep_q <= '0;
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
    end else begin
      if ((state_q == ACCESS) && PREADY) acc_q[ch_q] <= acc_q[ch_q] + ACC_W'(PRDATA);
      if ((state_q == NEXT) && last_ch_c) sweep_q <= sweep_q + 1'b1;
    end
  end

  // Published averages and alarms, updated only on entry to PUBLISH
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      alarm  <= '0;
    end else if (state_d == PUBLISH) begin
      for (int i = 0; i < NUM_CH; i++) begin
        result[16*i +: 16] <= avg_c[i];
        alarm[i]           <= (avg_c[i] > thr_hi[16*i +: 16]) ||
                              (avg_c[i] < thr_lo[16*i +: 16]);
      end
    end
  end

endmodule

// File: tb/tb_adc_drp_poller.sv
// Directed self-checking bench for adc_drp_poller (4 channels, 100-cycle tick).
module tb_adc_drp_poller;

  logic        clk = 1'b0;
  logic        rst, en, err_clr;
  logic [7:0]  PADDR;
  logic        PSEL, PENABLE, PWRITE, PREADY;
  logic [15:0] PWDATA, PRDATA;
  logic        cfg_req, cfg_we, cfg_ack, cfg_err;
  logic [7:0]  cfg_addr;
  logic [15:0] cfg_wdata, cfg_rdata;
  logic [63:0] thr_hi, thr_lo, result;
  logic        result_valid, timeout_err, overrun_err;
  logic [3:0]  alarm;

  int checks = 0;
  int errors = 0;

  // Register-port responder controls
  int          rd_delay   = 0;
  logic        stall_en   = 1'b0;
  logic [7:0]  stall_addr = 8'h00;
  logic        vary_ch1   = 1'b0;
  logic [15:0] ch1_start  = 16'h0;
  logic [15:0] ch1_reads  = 16'h0;
  logic [15:0] tbl [16];
  int          acc_cyc    = 0;
  int          rv_cnt     = 0;
  int          rv_snap;

  always #5 clk = ~clk;

  adc_drp_poller #(
    .NUM_CH(4), .CH_ADDR_BASE(8'h00), .POLL_DIV(100), .AVG_LOG2(2), .TIMEOUT_CYC(64)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .cfg_req(cfg_req), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .result(result), .result_valid(result_valid),
    .alarm(alarm), .timeout_err(timeout_err), .overrun_err(overrun_err), .err_clr(err_clr)
  );

  assign PREADY = PSEL && PENABLE && !(stall_en && (PADDR == stall_addr)) && (acc_cyc >= rd_delay);
  assign PRDATA = (vary_ch1 && (PADDR == 8'h01)) ? 16'h0FFF + (ch1_reads - ch1_start)
                                                 : tbl[PADDR[3:0]];

  always @(posedge clk) begin
    if (PSEL && PENABLE && !PREADY) acc_cyc <= acc_cyc + 1;
    else                            acc_cyc <= 0;
    if (PSEL && PENABLE && PREADY && !PWRITE && (PADDR == 8'h01)) ch1_reads <= ch1_reads + 16'd1;
    if (result_valid) rv_cnt <= rv_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; err_clr = 1'b0;
    cfg_req = 1'b0; cfg_we = 1'b0; cfg_addr = 8'h00; cfg_wdata = 16'h0000;
    for (int i = 0; i < 16; i++) tbl[i] = 16'h1000 + 16'(i);
    thr_hi = {16'h1002, 16'hFFFF, 16'hFFFF, 16'h1000};
    thr_lo = {16'h0000, 16'h1002, 16'h1002, 16'h0000};
    repeat (3) @(negedge clk);
    chk("rst_bus", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, '0);
    chk("rst_result", result, '0);
    chk("rst_flags", {alarm, timeout_err, overrun_err, cfg_ack, cfg_err, result_valid}, '0);
    rst = 1'b0; en = 1'b1;

    // Window 1: constant samples, threshold boundaries
    for (int i = 0; i < 1000 && !result_valid; i++) @(negedge clk);
    chk("w1_valid", result_valid, 1);
    chk("w1_result", result, 64'h1003_1002_1001_1000);
    chk("w1_alarm", alarm, 4'b1010);
    @(negedge clk);
    chk("w1_pulse", result_valid, 0);
    chk("w1_count", rv_cnt, 1);

    // Window 2: channel 1 varies across sweeps
    vary_ch1 = 1'b1; ch1_start = ch1_reads;
    thr_hi = {16'hFFFF, 16'hFFFF, 16'h1000, 16'hFFFF};
    thr_lo = {16'h0000, 16'h0000, 16'h0800, 16'h0000};
    for (int i = 0; i < 1000 && !result_valid; i++) @(negedge clk);
    chk("w2_valid", result_valid, 1);
    chk("w2_result", result, 64'h1003_1002_1000_1000);
    chk("w2_alarm", alarm, 4'b0000);
    @(negedge clk);

    // Window 3: channel 1 above its upper limit
    vary_ch1 = 1'b0; tbl[1] = 16'h2000;
    for (int i = 0; i < 1000 && !result_valid; i++) @(negedge clk);
    chk("w3_valid", result_valid, 1);
    chk("w3_result", result, 64'h1003_1002_2000_1000);
    chk("w3_alarm", alarm, 4'b0010);
    @(negedge clk);

    // Timeout on channel 2 discards the window
    tbl[1] = 16'h1001; thr_hi = '1; thr_lo = '0;
    stall_en = 1'b1; stall_addr = 8'h02; rv_snap = rv_cnt;
    for (int i = 0; i < 1000 && !timeout_err; i++) @(negedge clk);
    chk("to_seen", timeout_err, 1);
    chk("to_bus", {PSEL, PENABLE}, 2'b00);
    chk("to_result_kept", result, 64'h1003_1002_2000_1000);
    chk("to_alarm_kept", alarm, 4'b0010);
    chk("to_no_valid", rv_cnt, rv_snap);
    stall_en = 1'b0;
    for (int i = 0; i < 1000 && !result_valid; i++) @(negedge clk);
    chk("to_clean_valid", result_valid, 1);
    chk("to_clean_result", result, 64'h1003_1002_1001_1000);
    chk("to_clean_alarm", alarm, 4'b0000);
    chk("to_sticky", timeout_err, 1);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("to_clr", timeout_err, 0);

    // Cfg write raised together with a tick runs before the sweep
    for (int i = 0; i < 300 && !(PSEL && !PENABLE && (PADDR == 8'h00)); i++) @(negedge clk);
    chk("sw_start_seen", {PSEL, PENABLE, PADDR}, {1'b1, 1'b0, 8'h00});
    repeat (98) @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 8'h41; cfg_wdata = 16'hBEEF; cfg_req = 1'b1;
    @(negedge clk);
    chk("cfgw_setup", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {3'b101, 8'h41, 16'hBEEF});
    for (int i = 0; i < 100 && !cfg_ack; i++) @(negedge clk);
    chk("cfgw_ack", cfg_ack, 1);
    chk("cfgw_err", cfg_err, 0);
    cfg_req = 1'b0; cfg_we = 1'b0;
    for (int i = 0; i < 10 && !PSEL; i++) @(negedge clk);
    chk("sw_after_cfg", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {3'b100, 8'h00, 16'h0000});
    @(negedge clk);
    chk("sw_access", {PSEL, PENABLE}, 2'b11);
    @(negedge clk);
    chk("sw_next_idle", {PSEL, PENABLE}, 2'b00);
    @(negedge clk);
    chk("sw_ch1_setup", {PSEL, PENABLE, PADDR}, {2'b10, 8'h01});
    chk("no_overrun", overrun_err, 0);

    // Cfg read
    cfg_addr = 8'h03; cfg_req = 1'b1;
    for (int i = 0; i < 200 && !cfg_ack; i++) @(negedge clk);
    chk("cfgr_ack", cfg_ack, 1);
    chk("cfgr_data", {cfg_err, cfg_rdata}, {1'b0, 16'h1003});
    cfg_req = 1'b0;
    @(negedge clk);
    chk("cfgr_pulse", {cfg_ack, cfg_err}, 2'b00);

    // Cfg read timeout
    stall_en = 1'b1; stall_addr = 8'h55; cfg_addr = 8'h55; cfg_req = 1'b1;
    for (int i = 0; i < 300 && !cfg_ack; i++) @(negedge clk);
    chk("cfgto_ack", cfg_ack, 1);
    chk("cfgto_data", {cfg_err, cfg_rdata}, {1'b1, 16'h0000});
    chk("cfgto_no_sweep_err", timeout_err, 0);
    cfg_req = 1'b0; stall_en = 1'b0;
    @(negedge clk);

    // Slow reads stretch sweeps past the tick period
    chk("ovr_before", overrun_err, 0);
    rd_delay = 40;
    for (int i = 0; i < 1000 && !overrun_err; i++) @(negedge clk);
    chk("ovr_seen", overrun_err, 1);
    chk("ovr_no_timeout", timeout_err, 0);
    rd_delay = 0;
    repeat (20) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("ovr_clr", overrun_err, 0);

    // Reset in the middle of an access phase
    rd_delay = 10;
    for (int i = 0; i < 300 && !(PSEL && PENABLE); i++) @(negedge clk);
    chk("rst_mid_seen", {PSEL, PENABLE}, 2'b11);
    rst = 1'b1; rv_snap = rv_cnt;
    @(negedge clk);
    chk("rst_mid_bus", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, '0);
    chk("rst_mid_result", result, '0);
    chk("rst_mid_flags", {alarm, timeout_err, overrun_err, cfg_ack, cfg_err, result_valid}, '0);
    @(negedge clk);
    rst = 1'b0; rd_delay = 0;
    repeat (30) @(negedge clk);
    chk("rst_mid_no_valid", rv_cnt, rv_snap);
    chk("rst_mid_idle", PSEL, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
